// File: rtl/mm_job_queue.sv
// Job queue and dispatcher for the matrix-multiply engine: buffers job descriptors,
// issues them one at a time over a start/done handshake, and supervises each with a watchdog.
module mm_job_queue #(
    parameter int DEPTH   = 4,
    parameter int AW      = 32,
    parameter int TW      = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     job_valid,
    output logic                     job_ready,
    input  logic [AW-1:0]            job_addr,
    input  logic                     job_mode,
    input  logic [TW-1:0]            job_tag,
    input  logic                     flush,
    output logic                     mm_start,
    output logic [AW-1:0]            mm_addr,
    output logic                     mm_mode,
    input  logic                     mm_done,
    output logic                     cpl_valid,
    output logic [TW-1:0]            cpl_tag,
    output logic                     cpl_err,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   pending,
    output logic [15:0]              completed,
    output logic [7:0]               timeouts
);

    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam int TMW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_COMPLETE
    } state_t;

    state_t state, state_nx;

    logic [AW-1:0]  addr_mem [DEPTH];
    logic           mode_mem [DEPTH];
    logic [TW-1:0]  tag_mem  [DEPTH];

    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic [TMW-1:0] timer;
    logic [TW-1:0]  act_tag;
    logic           err_q;
    logic           push, pop;
    logic           wait_exit;

    assign job_ready = (count != CW'(DEPTH)) && !flush && !rst;
    assign push      = job_valid && job_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        pop       = 1'b0;
        wait_exit = 1'b0;
        case (state)
            S_IDLE: begin
                if ((count != '0) && !flush) begin
                    pop      = 1'b1;
                    state_nx = S_ISSUE;
                end
            end
            S_ISSUE: state_nx = S_WAIT;
            S_WAIT: begin
                // done has priority over the watchdog in the final WAIT cycle
                if (mm_done || (timer == TMW'(TIMEOUT - 1))) begin
                    wait_exit = 1'b1;
                    state_nx  = S_COMPLETE;
                end
            end
            S_COMPLETE: state_nx = S_IDLE;
            default:    state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= job_addr;
            mode_mem[wr_ptr] <= job_mode;
            tag_mem[wr_ptr]  <= job_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            mm_addr   <= '0;
            mm_mode   <= 1'b0;
            act_tag   <= '0;
            timer     <= '0;
            err_q     <= 1'b0;
            completed <= '0;
            timeouts  <= '0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
                if (push && !pop)      count <= count + CW'(1);
                else if (!push && pop) count <= count - CW'(1);
            end

            if (pop) begin
                mm_addr <= addr_mem[rd_ptr];
                mm_mode <= mode_mem[rd_ptr];
                act_tag <= tag_mem[rd_ptr];
            end

            if (state == S_ISSUE)     timer <= '0;
            else if (state == S_WAIT) timer <= timer + TMW'(1);

            if (wait_exit) err_q <= !mm_done;

            if (state == S_COMPLETE) begin
                if (!err_q)                completed <= completed + 16'd1;
                else if (timeouts != '1)   timeouts  <= timeouts + 8'd1;
            end
        end
    end

    assign mm_start  = (state == S_ISSUE);
    assign cpl_valid = (state == S_COMPLETE);
    assign cpl_tag   = act_tag;
    assign cpl_err   = cpl_valid && err_q;
    assign busy      = (state != S_IDLE);
    assign pending   = count;

endmodule

// File: tb/tb_mm_job_queue.sv
// Directed bench for mm_job_queue: latency, ordering, watchdog, flush and reset behaviour
// with hand-computed expectations (TIMEOUT=16, DEPTH=4).
module tb_mm_job_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        job_valid;
    logic        job_ready;
    logic [31:0] job_addr;
    logic        job_mode;
    logic [3:0]  job_tag;
    logic        flush;
    logic        mm_start;
    logic [31:0] mm_addr;
    logic        mm_mode;
    logic        mm_done;
    logic        cpl_valid;
    logic [3:0]  cpl_tag;
    logic        cpl_err;
    logic        busy;
    logic [2:0]  pending;
    logic [15:0] completed;
    logic [7:0]  timeouts;

    int n_checks = 0;
    int n_fail   = 0;
    int n_start  = 0;
    logic [4:0] cpl_q [$];

    mm_job_queue #(.DEPTH(4), .AW(32), .TW(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_addr(job_addr), .job_mode(job_mode), .job_tag(job_tag),
        .flush(flush),
        .mm_start(mm_start), .mm_addr(mm_addr), .mm_mode(mm_mode), .mm_done(mm_done),
        .cpl_valid(cpl_valid), .cpl_tag(cpl_tag), .cpl_err(cpl_err),
        .busy(busy), .pending(pending), .completed(completed), .timeouts(timeouts)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cpl_valid) cpl_q.push_back({cpl_err, cpl_tag});
        if (mm_start)  n_start++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic offer(input logic [31:0] a, input logic m, input logic [3:0] t);
        job_valid = 1'b1;
        job_addr  = a;
        job_mode  = m;
        job_tag   = t;
    endtask

    task automatic run_job(input int d, input logic [31:0] exp_addr, input string nm);
        for (int k = 0; k < 40; k++) begin
            smp();
            if (mm_start) break;
            next();
        end
        check({nm, "_start"}, 32'(mm_start), 1);
        check({nm, "_addr"}, mm_addr, exp_addr);
        repeat (d) next();
        mm_done = 1'b1;
        next();
        mm_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "bench time limit");
    end

    initial begin
        int k;
        int qsz;
        int st;
        rst = 1'b1; job_valid = 1'b0; job_addr = '0; job_mode = 1'b0;
        job_tag = '0; flush = 1'b0; mm_done = 1'b0;

        // reset state
        repeat (3) next();
        smp();
        check("rst_ready",     32'(job_ready), 0);
        check("rst_busy",      32'(busy), 0);
        check("rst_pending",   32'(pending), 0);
        check("rst_start",     32'(mm_start), 0);
        check("rst_cpl",       32'(cpl_valid), 0);
        check("rst_addr",      mm_addr, 0);
        check("rst_completed", 32'(completed), 0);
        check("rst_timeouts",  32'(timeouts), 0);
        next();
        rst = 1'b0;
        smp();
        check("ready_after_rst", 32'(job_ready), 1);

        // single job: accept n, pop n+1, start n+2, done 10 cycles after start
        next();
        offer(32'h1000, 1'b1, 4'd3);
        smp();
        check("single_ready", 32'(job_ready), 1);
        next();
        job_valid = 1'b0;
        smp();
        check("single_pop_pending", 32'(pending), 1);
        check("single_pop_busy", 32'(busy), 0);
        next();
        smp();
        check("single_start", 32'(mm_start), 1);
        check("single_addr", mm_addr, 32'h1000);
        check("single_mode", 32'(mm_mode), 1);
        repeat (10) next();
        mm_done = 1'b1;
        smp();
        check("single_no_early_cpl", 32'(cpl_valid), 0);
        next();
        mm_done = 1'b0;
        smp();
        check("single_cpl", 32'(cpl_valid), 1);
        check("single_tag", 32'(cpl_tag), 3);
        check("single_err", 32'(cpl_err), 0);
        next();
        smp();
        check("single_completed", 32'(completed), 1);
        check("single_idle", 32'(busy), 0);
        check("single_addr_hold", mm_addr, 32'h1000);

        // fill and order: five back-to-back pushes, one is popped into the active slot
        cpl_q.delete();
        next();
        for (int i = 0; i < 5; i++) begin
            offer(32'h2000 + 32'(i) * 32'h10, 1'(i), 4'(i));
            smp();
            check($sformatf("fill_ready_%0d", i), 32'(job_ready), 1);
            next();
        end
        job_valid = 1'b0;
        mm_done = 1'b1;
        smp();
        check("fill_full_ready", 32'(job_ready), 0);
        check("fill_full_pending", 32'(pending), 4);
        next();
        mm_done = 1'b0;
        smp();
        check("fill_cpl0", 32'(cpl_valid), 1);
        check("fill_cpl0_tag", 32'(cpl_tag), 0);
        next();
        smp();
        check("fill_pop_ready_low", 32'(job_ready), 0);
        check("fill_pop_pending", 32'(pending), 4);
        next();
        smp();
        check("fill_ready_reopen", 32'(job_ready), 1);
        check("fill_pending_3", 32'(pending), 3);
        check("fill_start1", 32'(mm_start), 1);
        check("fill_addr1", mm_addr, 32'h2010);
        check("fill_mode1", 32'(mm_mode), 1);
        next();
        mm_done = 1'b1;
        next();
        mm_done = 1'b0;
        run_job(2, 32'h2020, "fill2");
        run_job(1, 32'h2030, "fill3");
        run_job(3, 32'h2040, "fill4");
        repeat (4) next();
        smp();
        check("fill_cpl_count", 32'(cpl_q.size()), 5);
        for (int i = 0; i < cpl_q.size() && i < 5; i++) begin
            check($sformatf("fill_order_%0d", i), 32'(cpl_q[i][3:0]), 32'(i));
            check($sformatf("fill_err_%0d", i), 32'(cpl_q[i][4]), 0);
        end
        check("fill_completed", 32'(completed), 6);
        check("fill_empty", 32'(pending), 0);

        // watchdog: no done, completion with err exactly 17 cycles after start
        next();
        offer(32'h3000, 1'b0, 4'd7);
        next();
        offer(32'h3100, 1'b0, 4'd8);
        next();
        job_valid = 1'b0;
        smp();
        check("to_start", 32'(mm_start), 1);
        check("to_addr", mm_addr, 32'h3000);
        k = 1;
        while (k <= 40) begin
            next();
            smp();
            if (cpl_valid) break;
            k++;
        end
        check("to_latency", 32'(k), 17);
        check("to_err", 32'(cpl_err), 1);
        check("to_tag", 32'(cpl_tag), 7);
        next();
        smp();
        check("to_timeouts", 32'(timeouts), 1);
        check("to_completed", 32'(completed), 6);
        run_job(2, 32'h3100, "after_to");
        repeat (3) next();
        smp();
        check("after_to_completed", 32'(completed), 7);

        // done on the last WAIT cycle wins over the watchdog
        next();
        offer(32'h4000, 1'b0, 4'd9);
        next();
        job_valid = 1'b0;
        next();
        smp();
        check("edge_start", 32'(mm_start), 1);
        repeat (16) next();
        mm_done = 1'b1;
        next();
        mm_done = 1'b0;
        smp();
        check("edge_cpl", 32'(cpl_valid), 1);
        check("edge_err", 32'(cpl_err), 0);
        check("edge_tag", 32'(cpl_tag), 9);
        next();
        smp();
        check("edge_completed", 32'(completed), 8);
        check("edge_timeouts", 32'(timeouts), 1);

        // flush with one active job and three queued
        next();
        for (int i = 0; i < 4; i++) begin
            offer(32'h5000 + 32'(i), 1'b0, 4'(10 + i));
            next();
        end
        job_valid = 1'b0;
        flush = 1'b1;
        smp();
        check("flush_ready_low", 32'(job_ready), 0);
        check("flush_pending_before", 32'(pending), 3);
        next();
        flush = 1'b0;
        smp();
        check("flush_pending_after", 32'(pending), 0);
        check("flush_ready_after", 32'(job_ready), 1);
        check("flush_active_busy", 32'(busy), 1);
        st = n_start;
        mm_done = 1'b1;
        next();
        mm_done = 1'b0;
        smp();
        check("flush_cpl", 32'(cpl_valid), 1);
        check("flush_cpl_tag", 32'(cpl_tag), 10);
        check("flush_cpl_err", 32'(cpl_err), 0);
        repeat (30) next();
        smp();
        check("flush_no_start", 32'(n_start), 32'(st));
        check("flush_completed", 32'(completed), 9);

        // reset in WAIT with a queued job, then a spurious done while idle
        next();
        offer(32'h6000, 1'b1, 4'd14);
        next();
        offer(32'h6100, 1'b0, 4'd15);
        next();
        job_valid = 1'b0;
        smp();
        check("rw_start", 32'(mm_start), 1);
        next();
        next();
        rst = 1'b1;
        smp();
        check("rw_ready_in_rst", 32'(job_ready), 0);
        qsz = cpl_q.size();
        st = n_start;
        next();
        smp();
        check("rw_busy", 32'(busy), 0);
        check("rw_pending", 32'(pending), 0);
        check("rw_addr", mm_addr, 0);
        check("rw_mode", 32'(mm_mode), 0);
        check("rw_tag", 32'(cpl_tag), 0);
        check("rw_completed", 32'(completed), 0);
        check("rw_timeouts", 32'(timeouts), 0);
        next();
        rst = 1'b0;
        smp();
        check("rw_ready_after", 32'(job_ready), 1);
        mm_done = 1'b1;
        next();
        mm_done = 1'b0;
        repeat (5) next();
        smp();
        check("rw_no_cpl", 32'(cpl_q.size()), 32'(qsz));
        check("rw_no_start", 32'(n_start), 32'(st));
        check("rw_idle", 32'(busy), 0);
        check("rw_spurious_completed", 32'(completed), 0);
        check("rw_spurious_timeouts", 32'(timeouts), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
